// File: rtl/byte_cipher_pkg.sv
// byte_cipher_pkg: shared definitions for the byte_cipher_lanes slice.
//   - cipher_state_t : FSM state encoding (IDLE, ROUND, DONE)
//   - SBOX / sbox()  : AES forward substitution box
//   - rotl8()        : 8-bit rotate-left used to derive per-round key bytes
package byte_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } cipher_state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

endpackage

// File: rtl/byte_cipher_lane.sv
// byte_cipher_lane: one byte lane of the cipher.
// Holds the round state s, the ciphertext output register and (when
// BYTE_CIPHER_CHAIN_EN is defined) the chaining register.
//   clk, reset_n  : clock, async active-low reset
//   load          : beat accepted this cycle; seeds s from data_in
//   round_en      : a substitution round runs this cycle
//   last_round    : this round is the final one; result goes to data_out
//   clear_chain   : honoured new_message; chain restarts from zero
//   out_hs        : output handshake this cycle; chain takes data_out
//   rot_amt       : rotate amount for the round key, (r+1) mod 8
//   key_byte      : key byte in effect for this lane
//   data_in       : plaintext byte
//   data_out      : ciphertext byte
module byte_cipher_lane
  import byte_cipher_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       round_en,
  input  logic       last_round,
  input  logic       clear_chain,
  input  logic       out_hs,
  input  logic [2:0] rot_amt,
  input  logic [7:0] key_byte,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0] s_q;
  logic [7:0] s_round;
  logic [7:0] chain_next;

`ifdef BYTE_CIPHER_CHAIN_EN
  logic [7:0] chain_q;

  // chain_next is both the stored value and the one a same-cycle load sees,
  // so a back-to-back beat chains on the ciphertext being handed over.
  always_comb begin
    chain_next = chain_q;
    if (clear_chain)
      chain_next = '0;
    else if (out_hs)
      chain_next = data_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      chain_q <= '0;
    else
      chain_q <= chain_next;
  end
`else
  logic unused_chain_ctl;

  always_comb begin
    chain_next       = '0;
    unused_chain_ctl = clear_chain ^ out_hs;
  end
`endif

  always_comb begin
    s_round = sbox(s_q) ^ rotl8(key_byte, rot_amt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q      <= '0;
      data_out <= '0;
    end else if (load) begin
      s_q <= data_in ^ key_byte ^ chain_next;
    end else if (round_en) begin
      s_q <= s_round;
      if (last_round)
        data_out <= s_round;
    end
  end

endmodule

// File: rtl/byte_cipher_lanes.sv
// byte_cipher_lanes: LANES-wide byte substitution cipher, ROUNDS S-box
// rounds per beat, valid/ready on both sides, per-message key load.
// Optional cipher-block chaining: define BYTE_CIPHER_CHAIN_EN.
//   clk, reset_n           : clock, async active-low reset
//   new_message, key       : key load / chain clear (honoured when ready_in)
//   valid_in, ready_in     : input handshake, data_in plaintext
//   valid_out, ready_out   : output handshake, data_out ciphertext
//   busy                   : high in ROUND or DONE
//   beat_cnt               : beats accepted since new_message, saturating
module byte_cipher_lanes
  import byte_cipher_pkg::*;
#(
  parameter int unsigned LANES  = 1,
  parameter int unsigned ROUNDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               new_message,
  input  logic [8*LANES-1:0] key,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [8*LANES-1:0] data_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [8*LANES-1:0] data_out,
  output logic               busy,
  output logic [15:0]        beat_cnt
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);

  cipher_state_t      state_q, state_d;
  logic [CW-1:0]      rnd_q;
  logic [8*LANES-1:0] key_q;
  logic [8*LANES-1:0] key_eff;
  logic               accept, nm_take, out_hs, last_round, round_en;
  logic [2:0]         rot_amt;

  always_comb begin
    ready_in   = (state_q == IDLE) || ((state_q == DONE) && ready_out);
    valid_out  = (state_q == DONE);
    busy       = (state_q != IDLE);
    accept     = valid_in && ready_in;
    nm_take    = new_message && ready_in;
    out_hs     = valid_out && ready_out;
    round_en   = (state_q == ROUND);
    last_round = (rnd_q == CW'(ROUNDS - 1));
    rot_amt    = 3'(32'(rnd_q) + 32'd1);
    // A key loaded alongside an accept must already apply to that beat.
    key_eff    = nm_take ? key : key_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE:    if (ready_out) state_d = accept ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      key_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        rnd_q <= '0;
      else if (round_en)
        rnd_q <= rnd_q + CW'(1);
      if (nm_take)
        key_q <= key;
      if (nm_take)
        beat_cnt <= accept ? 16'd1 : 16'd0;
      else if (accept && (beat_cnt != 16'hFFFF))
        beat_cnt <= beat_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    byte_cipher_lane u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (accept),
      .round_en    (round_en),
      .last_round  (last_round),
      .clear_chain (nm_take),
      .out_hs      (out_hs),
      .rot_amt     (rot_amt),
      .key_byte    (key_eff[8*i +: 8]),
      .data_in     (data_in[8*i +: 8]),
      .data_out    (data_out[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_byte_cipher_lanes.sv
// Directed bench: dut_w is LANES=4/ROUNDS=1, dut_r is LANES=1/ROUNDS=4.
// Expected ciphertexts are hand-computed from the AES S-box; chained
// values apply when BYTE_CIPHER_CHAIN_EN is defined.
module tb_byte_cipher_lanes;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        w_new = 1'b0, w_valid_in = 1'b0, w_ready_out = 1'b1;
  logic [31:0] w_key = '0, w_data_in = '0;
  logic        w_ready_in, w_valid_out, w_busy;
  logic [31:0] w_data_out;
  logic [15:0] w_beat_cnt;

  logic        r_new = 1'b0, r_valid_in = 1'b0, r_ready_out = 1'b0;
  logic [7:0]  r_key = '0, r_data_in = '0;
  logic        r_ready_in, r_valid_out, r_busy;
  logic [7:0]  r_data_out;
  logic [15:0] r_beat_cnt;

  int errors = 0;
  int checks = 0;

  byte_cipher_lanes #(.LANES(4), .ROUNDS(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .new_message(w_new), .key(w_key),
    .valid_in(w_valid_in), .ready_in(w_ready_in), .data_in(w_data_in),
    .valid_out(w_valid_out), .ready_out(w_ready_out), .data_out(w_data_out),
    .busy(w_busy), .beat_cnt(w_beat_cnt)
  );

  byte_cipher_lanes #(.LANES(1), .ROUNDS(4)) dut_r (
    .clk(clk), .reset_n(reset_n), .new_message(r_new), .key(r_key),
    .valid_in(r_valid_in), .ready_in(r_ready_in), .data_in(r_data_in),
    .valid_out(r_valid_out), .ready_out(r_ready_out), .data_out(r_data_out),
    .busy(r_busy), .beat_cnt(r_beat_cnt)
  );

  // Transaction drivers (no checking): lat = posedges from accept to valid_out.
  task automatic send_w(input logic nm, input logic [31:0] k, input logic [31:0] d,
                        output logic [31:0] got, output int lat);
    int n;
    @(negedge clk);
    w_new = nm; w_key = k; w_data_in = d; w_valid_in = 1'b1;
    n = 0;
    while (!w_ready_in && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    w_valid_in = 1'b0; w_new = 1'b0;
    lat = 0;
    while (!w_valid_out && lat < 50) begin @(posedge clk); #1; lat++; end
    got = w_data_out;
  endtask

  task automatic send_r(input logic nm, input logic [7:0] k, input logic [7:0] d,
                        output logic [7:0] got, output int lat);
    int n;
    @(negedge clk);
    r_new = nm; r_key = k; r_data_in = d; r_valid_in = 1'b1;
    n = 0;
    while (!r_ready_in && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    r_valid_in = 1'b0; r_new = 1'b0;
    lat = 0;
    while (!r_valid_out && lat < 50) begin @(posedge clk); #1; lat++; end
    got = r_data_out;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({w_ready_in, w_valid_out, w_busy} !== 3'b100) begin errors++; $display("FAIL reset_w_ctl: got %b expected 100", {w_ready_in, w_valid_out, w_busy}); end
    checks++; if (w_data_out !== 32'h0) begin errors++; $display("FAIL reset_w_data: got %h expected 00000000", w_data_out); end
    checks++; if (w_beat_cnt !== 16'h0) begin errors++; $display("FAIL reset_w_cnt: got %h expected 0000", w_beat_cnt); end
    checks++; if ({r_ready_in, r_valid_out, r_busy} !== 3'b100) begin errors++; $display("FAIL reset_r_ctl: got %b expected 100", {r_ready_in, r_valid_out, r_busy}); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_ecb_basic;
    logic [31:0] got; int lat;
    send_w(1'b1, 32'h0, 32'h0, got, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_lat1: got %0d expected 1", lat); end
    checks++; if (got !== 32'h63636363) begin errors++; $display("FAIL basic_beat1: got %h expected 63636363", got); end
    send_w(1'b0, 32'h0, 32'h1, got, lat);
`ifdef BYTE_CIPHER_CHAIN_EN
    checks++; if (got !== 32'hFBFBFBAA) begin errors++; $display("FAIL basic_beat2: got %h expected fbfbfbaa", got); end
`else
    checks++; if (got !== 32'h6363637C) begin errors++; $display("FAIL basic_beat2: got %h expected 6363637c", got); end
`endif
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_lat2: got %0d expected 1", lat); end
    checks++; if (w_beat_cnt !== 16'd2) begin errors++; $display("FAIL basic_cnt: got %0d expected 2", w_beat_cnt); end
  endtask

  task automatic test_round_key;
    logic [31:0] got; int lat;
    send_w(1'b1, 32'h1, 32'h1, got, lat);
    checks++; if (got !== 32'h63636361) begin errors++; $display("FAIL rkey_beat1: got %h expected 63636361", got); end
    checks++; if (w_beat_cnt !== 16'd1) begin errors++; $display("FAIL rkey_cnt1: got %0d expected 1", w_beat_cnt); end
    send_w(1'b0, 32'hA5A5A5A5, 32'h1, got, lat);
`ifdef BYTE_CIPHER_CHAIN_EN
    checks++; if (got !== 32'hFBFBFBED) begin errors++; $display("FAIL rkey_beat2: got %h expected fbfbfbed", got); end
`else
    checks++; if (got !== 32'h63636361) begin errors++; $display("FAIL rkey_beat2: got %h expected 63636361", got); end
`endif
    checks++; if (w_beat_cnt !== 16'd2) begin errors++; $display("FAIL rkey_cnt2: got %0d expected 2", w_beat_cnt); end
  endtask

  task automatic test_chain_restart;
    logic [31:0] got; int lat;
    send_w(1'b1, 32'h0, 32'h0, got, lat);
    checks++; if (got !== 32'h63636363) begin errors++; $display("FAIL restart_beat: got %h expected 63636363", got); end
    checks++; if (w_beat_cnt !== 16'd1) begin errors++; $display("FAIL restart_cnt: got %0d expected 1", w_beat_cnt); end
  endtask

  task automatic test_lanes;
    logic [31:0] got; int lat;
    send_w(1'b1, 32'h0, 32'h03020100, got, lat);
    checks++; if (got !== 32'h7B777C63) begin errors++; $display("FAIL lanes_beat: got %h expected 7b777c63", got); end
  endtask

  task automatic test_back_to_back;
    int lat;
    r_ready_out = 1'b0;
    @(negedge clk);
    r_new = 1'b1; r_key = 8'h0; r_data_in = 8'h0; r_valid_in = 1'b1;
    @(posedge clk); #1;
    r_new = 1'b0;
    lat = 0;
    while (!r_valid_out && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat1: got %0d expected 4", lat); end
    checks++; if (r_data_out !== 8'h76) begin errors++; $display("FAIL b2b_data1: got %h expected 76", r_data_out); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({r_valid_out, r_data_out} !== {1'b1, 8'h76}) begin errors++; $display("FAIL hold_out[%0d]: got %b/%h expected 1/76", i, r_valid_out, r_data_out); end
      checks++; if ({r_ready_in, r_busy} !== 2'b01) begin errors++; $display("FAIL hold_ctl[%0d]: got %b expected 01", i, {r_ready_in, r_busy}); end
      checks++; if (r_beat_cnt !== 16'd1) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 1", i, r_beat_cnt); end
    end
    @(negedge clk); r_ready_out = 1'b1;
    @(posedge clk); #1;
    r_ready_out = 1'b0; r_valid_in = 1'b0;
    checks++; if ({r_valid_out, r_busy} !== 2'b01) begin errors++; $display("FAIL b2b_accept: got %b expected 01", {r_valid_out, r_busy}); end
    checks++; if (r_beat_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d expected 2", r_beat_cnt); end
    lat = 0;
    while (!r_valid_out && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat2: got %0d expected 4", lat); end
`ifdef BYTE_CIPHER_CHAIN_EN
    checks++; if (r_data_out !== 8'hA6) begin errors++; $display("FAIL b2b_data2: got %h expected a6", r_data_out); end
`else
    checks++; if (r_data_out !== 8'h76) begin errors++; $display("FAIL b2b_data2: got %h expected 76", r_data_out); end
`endif
    @(negedge clk); r_ready_out = 1'b1;
    @(posedge clk); #1;
    checks++; if ({r_valid_out, r_ready_in, r_busy} !== 3'b010) begin errors++; $display("FAIL b2b_idle: got %b expected 010", {r_valid_out, r_ready_in, r_busy}); end
  endtask

  task automatic test_reset_midround;
    logic [7:0] got; int lat;
    r_ready_out = 1'b1;
    @(negedge clk);
    r_new = 1'b1; r_key = 8'h55; r_data_in = 8'h12; r_valid_in = 1'b1;
    @(posedge clk); #1;
    r_new = 1'b0; r_valid_in = 1'b0;
    @(posedge clk); #3;
    checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", r_busy); end
    reset_n = 1'b0;
    #1;
    checks++; if ({r_valid_out, r_ready_in, r_busy} !== 3'b010) begin errors++; $display("FAIL mid_reset_ctl: got %b expected 010", {r_valid_out, r_ready_in, r_busy}); end
    checks++; if (r_beat_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", r_beat_cnt); end
    checks++; if (r_data_out !== 8'h0) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", r_data_out); end
    @(negedge clk); reset_n = 1'b1;
    send_r(1'b0, 8'hFF, 8'h0, got, lat);
    checks++; if (got !== 8'h76) begin errors++; $display("FAIL post_reset_key0: got %h expected 76", got); end
    send_r(1'b1, 8'h01, 8'h01, got, lat);
    checks++; if (got !== 8'hE8) begin errors++; $display("FAIL post_reset_newkey: got %h expected e8", got); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_lat: got %0d expected 4", lat); end
    checks++; if (r_beat_cnt !== 16'd1) begin errors++; $display("FAIL post_reset_cnt: got %0d expected 1", r_beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_ecb_basic();
    test_round_key();
    test_chain_restart();
    test_lanes();
    test_back_to_back();
    test_reset_midround();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/byte_cipher_lanes.md
# byte_cipher_lanes

Parametrised multi-lane byte-stream substitution cipher, successor to the single-byte cipher core. Encrypts LANES bytes per beat through ROUNDS iterative S-box rounds, with a valid/ready handshake on both sides (output backpressure), a per-message key load, and optional cipher-block chaining. It sits between the message byte source and the output serializer.

## Interface
- LANES, 1: bytes processed per beat; each lane is independent.
- ROUNDS, 4: substitution rounds per beat, minimum 1.
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- new_message  in  1  key-load / chain-clear strobe.
- key  in  8*LANES  message key; byte i keys lane i.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block can accept a beat.
- data_in  in  8*LANES  plaintext; byte i feeds lane i.
- valid_out  out  1  ciphertext valid; held until accepted.
- ready_out  in  1  downstream accepts data_out.
- data_out  out  8*LANES  ciphertext.
- busy  out  1  high in ROUND or DONE.
- beat_cnt  out  16  beats accepted since last new_message, saturating at 0xFFFF.

## Operation
- FSM states: IDLE, ROUND, DONE.
- Reset values: state IDLE, ready_in 1, valid_out 0, data_out 0, busy 0, beat_cnt 0, key register 0, chain registers 0.
- ready_in = (state==IDLE) || (state==DONE && ready_out). Accept = valid_in && ready_in.
- new_message is honoured only when ready_in=1. It loads key into the key register, clears all chain registers and clears beat_cnt. If it is asserted in the same cycle as an accept, the new key and zero chain apply to that beat, and beat_cnt becomes 1. When ready_in=0, new_message is ignored.
- On accept, per lane: s = data_in[i] ^ K[i] ^ C[i]. The FSM moves to ROUND with r=0, and beat_cnt increments (saturating).
- Each ROUND cycle: s = SBOX(s) ^ rotl8(K[i], (r+1) mod 8), then r++. When the cycle with r==ROUNDS-1 completes, the FSM moves to DONE and data_out = s.
- DONE: valid_out=1, and data_out is held stable until ready_out.
  - ready_out with no accept → IDLE.
  - ready_out with an accept in the same cycle → ROUND directly (back-to-back).
- Chain update: C[i] takes data_out[i] on every output handshake (see Configuration).
- SBOX is the standard AES forward S-box.
- All arithmetic is 8-bit XOR and rotate. There is no carry.
- The round counter is $clog2(ROUNDS+1) bits wide and resets to 0 on every accept.

## Timing
- Latency: valid_out rises ROUNDS cycles after the accept edge.
- Throughput: one beat per ROUNDS+1 cycles when ready_out is held high. The back-to-back path removes the IDLE cycle.
- valid_out is never withdrawn without a ready_out handshake.
- data_out does not change while valid_out=1 && !ready_out.
- If reset_n is asserted mid-ROUND or mid-DONE, the in-flight beat is discarded and every output returns to its reset value immediately (asynchronously).
- valid_in while busy and not in DONE with ready_out: no accept. The source must hold data_in.
- beat_cnt at 0xFFFF stays 0xFFFF.

## Configuration
- Macro: BYTE_CIPHER_CHAIN_EN.
  - Defined: chaining active. C[i] ← data_out[i] on each output handshake. On a back-to-back accept, the incoming beat uses the data_out value being handed over in that same cycle.
  - Undefined: chain registers are not built and C[i] reads as constant 0 (ECB behaviour). new_message still reloads the key and clears beat_cnt.

## Structure
- Package byte_cipher_pkg holds:
  - the 256-entry SBOX constant and sbox() function;
  - the rotl8() function;
  - the FSM state enum typedef (IDLE, ROUND, DONE).
- Sub-module byte_cipher_lane holds the per-lane state register s, the chain register and the round datapath. It is instantiated LANES times via generate.
- The top holds the FSM, round counter, key register, beat_cnt and handshake logic.

## Test plan
- LANES=1, ROUNDS=1, chaining off; new_message with key=0x00; data 0x00 then 0x01 → data_out 0x63 then 0x7C, each valid 1 cycle after accept; beat_cnt=2.
- LANES=1, ROUNDS=1, key=0x01, data 0x01 → s=0x00, SBOX=0x63, ^0x02 → data_out 0x61.
- BYTE_CIPHER_CHAIN_EN defined, ROUNDS=1, key=0x00; data 0x00, 0x00 → 0x63, then 0xFB (0x00^0x63 → SBOX(0x63)). A new_message before a third beat of 0x00 → 0x63 again.
- ROUNDS=4: hold ready_out=0 for 5 cycles after valid_out rises → data_out stable, ready_in=0, valid_out held. Then release ready_out with valid_in high → back-to-back accept and the next valid_out 4 cycles later.
- LANES=4, key=0x00000000, data 0x03020100, ROUNDS=1 → data_out 0x7B777C63; each lane is independent.
- Assert reset_n low mid-ROUND → valid_out=0, ready_in=1, beat_cnt=0. After release, the beat following new_message encrypts with the fresh key and zero chain.
